// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: default word width, supported SPI mode and receiver states.
package spi_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int SPI_MODE   = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with registered level and
// single-cycle rise/fall pulses taken against one extra registered copy.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Synchronizer chain, edge-reference copy and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver with a valid/ready word output, overrun and framing pulses.
// Define SPI_SLAVE_TX_EN to add the tx_data port and drive spi_miso from a transmit shifter.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err
`ifdef SPI_SLAVE_TX_EN
  ,
  input  logic [DATA_W-1:0] tx_data
`endif
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_cs, w_cs_rise, w_cs_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(spi_clk),
    .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(spi_cs),
    .o_level(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;
  logic              r_frame_err;
  logic [DATA_W-1:0] w_word;
  logic              w_last_bit;

  assign w_word     = {r_shift[DATA_W-2:0], w_mosi};
  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  // Receive FSM: bit shifting, word hand-off, overrun and framing-error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_shift <= '0;
          if (!w_cs) begin
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (w_cs) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= (r_cnt != '0);
          end else if (w_sclk_rise) begin
            r_shift <= w_word;
            if (w_last_bit) begin
              r_cnt <= '0;
              // A consumer accepting in this same cycle frees the slot for the new word.
              if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= w_word;
                r_rx_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_shift <= '0;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

`ifdef SPI_SLAVE_TX_EN
  logic [DATA_W-1:0] r_tx_shift;
  logic              w_word_done;
  logic              w_unused;

  assign w_word_done = (r_state == SHIFT) && !w_cs && w_sclk_rise && w_last_bit;

  // Transmit shifter: reload at frame start and word boundaries, shift on SCLK falls.
  // The fall right after a word boundary is skipped so the fresh word keeps its MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_cs) begin
            r_tx_shift <= tx_data;
          end else begin
            r_tx_shift <= '0;
          end
        end
        SHIFT: begin
          if (w_cs) begin
            r_tx_shift <= '0;
          end else if (w_word_done) begin
            r_tx_shift <= tx_data;
          end else if (w_sclk_fall && (r_cnt != '0)) begin
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
          r_tx_shift <= '0;
        end
      endcase
    end
  end

  assign spi_miso = r_tx_shift[DATA_W-1];
  assign w_unused = &{1'b0, w_sclk, w_mosi_rise, w_mosi_fall, w_cs_rise, w_cs_fall};
`else
  logic w_unused;

  assign spi_miso = 1'b0;
  assign w_unused = &{1'b0, w_sclk, w_sclk_fall, w_mosi_rise, w_mosi_fall, w_cs_rise, w_cs_fall};
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: vector table, corner-case sequences and
// randomized frames checked against a word-level reference model.
module tb_spi_slave_rx;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          spi_clk;
  logic          spi_mosi;
  logic          spi_cs;
  logic          spi_miso;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          overrun;
  logic          frame_err;
`ifdef SPI_SLAVE_TX_EN
  logic [DW-1:0] tx_data;
  localparam logic [DW-1:0] TX_EXP = 8'h96;
`else
  localparam logic [DW-1:0] TX_EXP = 8'h00;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] got_q[$];
  int            ov_cnt = 0;
  int            fe_cnt = 0;
  logic [DW-1:0] miso_word = '0;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .frame_err(frame_err)
`ifdef SPI_SLAVE_TX_EN
    , .tx_data(tx_data)
`endif
  );

  // Output monitor: delivered words and pulse counts.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [DW-1:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = v[DW-1-i];
      wait_clk(HALF);
      miso_word = {miso_word[DW-2:0], spi_miso};
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(4 * HALF);
    #1;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            nbits;
    logic [DW-1:0] exp_data;
    int            exp_words;
    int            exp_fe;
  } vec_t;

  vec_t          vecs[7];
  logic [DW-1:0] exp_q[$];
  int            base_w, base_fe, base_ov, exp_fe;
  logic [DW-1:0] w;

  initial begin
    vecs[0] = '{8'hA5, 8, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 8, 8'h3C, 1, 0};
    vecs[2] = '{8'h00, 8, 8'h00, 1, 0};
    vecs[3] = '{8'hFF, 8, 8'hFF, 1, 0};
    vecs[4] = '{8'hFF, 5, 8'h00, 0, 1};
    vecs[5] = '{8'h81, 1, 8'h00, 0, 1};
    vecs[6] = '{8'h5A, 7, 8'h00, 0, 1};

    rst_n = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; rx_ready = 1'b1;
`ifdef SPI_SLAVE_TX_EN
    tx_data = 8'h96;
`endif
    wait_clk(3);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_miso", spi_miso, 1'b0);
    rst_n = 1'b1;
    wait_clk(HALF);

    // Table-driven single frames.
    for (int k = 0; k < 7; k++) begin
      base_w = got_q.size(); base_fe = fe_cnt;
      cs_begin();
      send_bits(vecs[k].data, vecs[k].nbits);
      cs_end();
      chk($sformatf("vec%0d_words", k), got_q.size() - base_w, vecs[k].exp_words);
      if (vecs[k].exp_words > 0) chk($sformatf("vec%0d_data", k), got_q[base_w], vecs[k].exp_data);
      chk($sformatf("vec%0d_frame_err", k), fe_cnt - base_fe, vecs[k].exp_fe);
      chk($sformatf("vec%0d_valid_idle", k), rx_valid, 1'b0);
    end

    // Exact hand-off latency for 0xA5 with rx_ready held high.
    cs_begin();
    send_bits(8'hA5, 7);
    spi_mosi = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b1;
    wait_clk(SS + 1);
    chk("lat_early", rx_valid, 1'b0);
    wait_clk(1);
    chk("lat_valid", rx_valid, 1'b1);
    chk("lat_data", rx_data, 8'hA5);
    wait_clk(1);
    chk("lat_one_cycle", rx_valid, 1'b0);
    wait_clk(HALF - SS - 3);
    spi_clk = 1'b0;
    cs_end();

    // Back-to-back words with the consumer stalled: second word overruns.
    rx_ready = 1'b0;
    base_ov = ov_cnt; base_w = got_q.size();
    cs_begin();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    cs_end();
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_data_held", rx_data, 8'h3C);
    chk("ovr_pulses", ov_cnt - base_ov, 1);

    // Word completing in the accept cycle replaces the held word without overrun.
    base_ov = ov_cnt;
    cs_begin();
    send_bits(8'hE7, 7);
    spi_mosi = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    wait_clk(1);
    chk("same_cycle_valid", rx_valid, 1'b1);
    chk("same_cycle_data", rx_data, 8'hE7);
    chk("same_cycle_consumed", got_q[got_q.size()-1], 8'h3C);
    wait_clk(HALF - 4);
    spi_clk = 1'b0;
    cs_end();
    chk("same_cycle_no_ovr", ov_cnt - base_ov, 0);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    wait_clk(3);
    #1;
    chk("same_cycle_drain", got_q[got_q.size()-1], 8'hE7);
    chk("same_cycle_cleared", rx_valid, 1'b0);
    chk("ovr_total_words", got_q.size() - base_w, 2);

    // Mid-word deselect, then a clean word.
    base_w = got_q.size(); base_fe = fe_cnt;
    cs_begin();
    send_bits(8'hFF, 5);
    cs_end();
    cs_begin();
    send_bits(8'h12, 8);
    cs_end();
    chk("ferr_pulses", fe_cnt - base_fe, 1);
    chk("ferr_words", got_q.size() - base_w, 1);
    chk("ferr_data", got_q[base_w], 8'h12);

    // Reset in the middle of 0x81.
    base_w = got_q.size(); base_fe = fe_cnt;
    cs_begin();
    send_bits(8'h81, 4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", rx_data, 8'h00);
    chk("rst_mid_valid", rx_valid, 1'b0);
    chk("rst_mid_ovr", overrun, 1'b0);
    chk("rst_mid_ferr", frame_err, 1'b0);
    chk("rst_mid_miso", spi_miso, 1'b0);
    spi_cs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(HALF);
    cs_begin();
    send_bits(8'h55, 8);
    cs_end();
    chk("rst_words", got_q.size() - base_w, 1);
    chk("rst_data", got_q[base_w], 8'h55);
    chk("rst_no_ferr", fe_cnt - base_fe, 0);

    // SCLK activity with cs high is ignored.
    base_w = got_q.size(); base_fe = fe_cnt;
    send_bits(8'hFF, 8);
    wait_clk(4 * HALF);
    #1;
    chk("idle_words", got_q.size() - base_w, 0);
    chk("idle_ferr", fe_cnt - base_fe, 0);

    // Reply word on MISO, two words per frame.
    cs_begin();
    send_bits(8'h00, 8);
    chk("miso_word0", miso_word, TX_EXP);
    send_bits(8'h00, 8);
    chk("miso_word1", miso_word, TX_EXP);
    cs_end();
    chk("miso_idle", spi_miso, 1'b0);

    // Randomized frames against the word-level model.
    base_w = got_q.size(); base_fe = fe_cnt; base_ov = ov_cnt;
    exp_fe = 0;
    exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      int nwords, partial;
      nwords  = $urandom_range(1, 3);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      cs_begin();
      for (int n = 0; n < nwords; n++) begin
        w = DW'($urandom);
        exp_q.push_back(w);
        send_bits(w, 8);
      end
      if (partial > 0) begin
        exp_fe++;
        w = DW'($urandom);
        send_bits(w, partial);
      end
      cs_end();
    end
    chk("rand_words", got_q.size() - base_w, exp_q.size());
    for (int i = 0; i < exp_q.size() && (base_w + i) < got_q.size(); i++) begin
      chk($sformatf("rand_data%0d", i), got_q[base_w+i], exp_q[i]);
    end
    chk("rand_ferr", fe_cnt - base_fe, exp_fe);
    chk("rand_no_ovr", ov_cnt - base_ov, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
